reg_ctrl_sequencer: RTL and testbench

//  Control end of the 4-entry register file: accepts 8-bit instruction bytes from fetch (valid/ready),

---
 rtl/reg_ctrl_pkg.sv | 38 +++
 rtl/reg_ctrl_sequencer.sv | 139 +++++++++++++
 tb/tb_reg_ctrl_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared encodings for the register-file control sequencer: opcodes, ALU functions,
// FSM states and the 2-to-4 one-hot select helper.
package reg_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDA = 4'd1,
    OP_STA = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_MOV = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    HALT   = 3'd4
  } state_e;

  function automatic logic [3:0] onehot2(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/reg_ctrl_sequencer.sv
// Decode/sequence control for the 4-entry register file, accumulator and ALU.
// Optional REGCTRL_ILLEGAL_TRAP_EN: illegal instructions set sticky IllegalOp and park in HALT.
module reg_ctrl_sequencer
  import reg_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic       InstrValid,
  input  logic [7:0] Instr,
  output logic       InstrReady,
  output logic [3:0] RegNum,
  output logic       RegCE,
  output logic       AccCE,
  output logic [2:0] AluOp,
  output logic       Busy,
  output logic       IllegalOp
);

  state_e     state;
  logic [7:0] instrQ;
  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       illegal;
  logic       needRead;
  logic       needWrite;
  alu_op_e    decAlu;

  assign op = instrQ[7:4];
  assign rd = instrQ[3:2];
  assign rs = instrQ[1:0];

  // R3 is a read-only input port, so any instruction writing it is rejected.
  always_comb begin
    illegal   = 1'b0;
    needRead  = 1'b0;
    needWrite = 1'b0;
    decAlu    = ALU_PASS;
    case (op)
      OP_NOP: ;
      OP_LDA: needRead = 1'b1;
      OP_STA: begin
        if (rd == 2'd3) illegal = 1'b1;
        else            needWrite = 1'b1;
      end
      OP_ADD: begin needRead = 1'b1; decAlu = ALU_ADD; end
      OP_SUB: begin needRead = 1'b1; decAlu = ALU_SUB; end
      OP_AND: begin needRead = 1'b1; decAlu = ALU_AND; end
      OP_OR:  begin needRead = 1'b1; decAlu = ALU_OR;  end
      OP_XOR: begin needRead = 1'b1; decAlu = ALU_XOR; end
      OP_MOV: begin
        if (rd == 2'd3) illegal = 1'b1;
        else begin
          needRead  = 1'b1;
          needWrite = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Outputs are computed for the state being entered so they are registered with it.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      instrQ     <= 8'h00;
      RegNum     <= 4'b0000;
      RegCE      <= 1'b0;
      AccCE      <= 1'b0;
      AluOp      <= ALU_PASS;
      IllegalOp  <= 1'b0;
      InstrReady <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      RegNum     <= 4'b0000;
      RegCE      <= 1'b0;
      AccCE      <= 1'b0;
      AluOp      <= ALU_PASS;
      InstrReady <= 1'b0;
      Busy       <= 1'b1;
      case (state)
        IDLE: begin
          if (InstrValid && InstrReady) begin
            instrQ <= Instr;
            state  <= DECODE;
          end else begin
            InstrReady <= 1'b1;
            Busy       <= 1'b0;
          end
        end
        DECODE: begin
          if (illegal) begin
`ifdef REGCTRL_ILLEGAL_TRAP_EN
            IllegalOp <= 1'b1;
            state     <= HALT;
`else
            state      <= IDLE;
            InstrReady <= 1'b1;
            Busy       <= 1'b0;
`endif
          end else if (needRead) begin
            state  <= READ;
            RegNum <= onehot2(rs);
            AccCE  <= 1'b1;
            AluOp  <= decAlu;
          end else if (needWrite) begin
            state  <= WRITE;
            RegNum <= onehot2(rd);
            RegCE  <= 1'b1;
          end else begin
            state      <= IDLE;
            InstrReady <= 1'b1;
            Busy       <= 1'b0;
          end
        end
        READ: begin
          if (needWrite) begin
            state  <= WRITE;
            RegNum <= onehot2(rd);
            RegCE  <= 1'b1;
          end else begin
            state      <= IDLE;
            InstrReady <= 1'b1;
            Busy       <= 1'b0;
          end
        end
`ifdef REGCTRL_ILLEGAL_TRAP_EN
        HALT: state <= HALT;
`endif
        default: begin
          state      <= IDLE;
          InstrReady <= 1'b1;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Directed bench for reg_ctrl_sequencer; illegal-op checks follow REGCTRL_ILLEGAL_TRAP_EN.
module tb_reg_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       Reset;
  logic       InstrValid;
  logic [7:0] Instr;
  logic       InstrReady;
  logic [3:0] RegNum;
  logic       RegCE;
  logic       AccCE;
  logic [2:0] AluOp;
  logic       Busy;
  logic       IllegalOp;

  int compared = 0;
  int mismatched = 0;
  int accepts;
  int reads;

  reg_ctrl_sequencer dut (
    .clk       (clk),
    .Reset     (Reset),
    .InstrValid(InstrValid),
    .Instr     (Instr),
    .InstrReady(InstrReady),
    .RegNum    (RegNum),
    .RegCE     (RegCE),
    .AccCE     (AccCE),
    .AluOp     (AluOp),
    .Busy      (Busy),
    .IllegalOp (IllegalOp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".RegCE"}, {7'd0, RegCE}, 8'd0);
    chk({tag, ".AccCE"}, {7'd0, AccCE}, 8'd0);
    chk({tag, ".RegNum"}, {4'd0, RegNum}, 8'd0);
    chk({tag, ".InstrReady"}, {7'd0, InstrReady}, 8'd1);
    chk({tag, ".Busy"}, {7'd0, Busy}, 8'd0);
    chk({tag, ".IllegalOp"}, {7'd0, IllegalOp}, 8'd0);
  endtask

  task automatic issue(input logic [7:0] ins);
    Instr = ins;
    InstrValid = 1'b1;
    tick();
    InstrValid = 1'b0;
    Instr = 8'hFF;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    InstrValid = 1'b0;
    Instr = 8'h00;
    tick();
    tick();
    Reset = 1'b0;

    // 1: reset held three cycles in the middle of a MOV
    issue(8'h8B);
    tick();
    chk("rst.midMovAccCE", {7'd0, AccCE}, 8'd1);
    Reset = 1'b1;
    tick();
    chk("rst.firstCycleRegCE", {7'd0, RegCE}, 8'd0);
    tick();
    tick();
    Reset = 1'b0;
    chkIdle("rst.after");
    tick();
    chkIdle("rst.hold");

    // 2: LDA R2
    issue(8'h12);
    chk("lda.e0.InstrReady", {7'd0, InstrReady}, 8'd0);
    chk("lda.e0.Busy", {7'd0, Busy}, 8'd1);
    chk("lda.e0.AccCE", {7'd0, AccCE}, 8'd0);
    tick();
    chk("lda.e1.AccCE", {7'd0, AccCE}, 8'd1);
    chk("lda.e1.RegCE", {7'd0, RegCE}, 8'd0);
    chk("lda.e1.RegNum", {4'd0, RegNum}, 8'h04);
    chk("lda.e1.AluOp", {5'd0, AluOp}, 8'd0);
    chk("lda.e1.InstrReady", {7'd0, InstrReady}, 8'd0);
    tick();
    chkIdle("lda.e2");

    // 3: STA R1
    issue(8'h24);
    tick();
    chk("sta.e1.RegCE", {7'd0, RegCE}, 8'd1);
    chk("sta.e1.RegNum", {4'd0, RegNum}, 8'h02);
    chk("sta.e1.AccCE", {7'd0, AccCE}, 8'd0);
    tick();
    chkIdle("sta.e2");

    // 4: MOV R2,R3
    issue(8'h8B);
    tick();
    chk("mov.e1.AccCE", {7'd0, AccCE}, 8'd1);
    chk("mov.e1.RegCE", {7'd0, RegCE}, 8'd0);
    chk("mov.e1.RegNum", {4'd0, RegNum}, 8'h08);
    chk("mov.e1.AluOp", {5'd0, AluOp}, 8'd0);
    tick();
    chk("mov.e2.RegCE", {7'd0, RegCE}, 8'd1);
    chk("mov.e2.AccCE", {7'd0, AccCE}, 8'd0);
    chk("mov.e2.RegNum", {4'd0, RegNum}, 8'h04);
    chk("mov.e2.InstrReady", {7'd0, InstrReady}, 8'd0);
    tick();
    chkIdle("mov.e3");

    // 5: ADD R1 with InstrValid held high for nine edges
    Instr = 8'h31;
    InstrValid = 1'b1;
    accepts = 0;
    reads = 0;
    for (int k = 0; k < 9; k++) begin
      if (InstrReady) accepts++;
      tick();
      chk($sformatf("add.k%0d.AccCE", k), {7'd0, AccCE}, ((k % 3) == 1) ? 8'd1 : 8'd0);
      if (AccCE) begin
        reads++;
        chk($sformatf("add.k%0d.AluOp", k), {5'd0, AluOp}, 8'd1);
        chk($sformatf("add.k%0d.RegNum", k), {4'd0, RegNum}, 8'h02);
      end
      chk($sformatf("add.k%0d.RegCE", k), {7'd0, RegCE}, 8'd0);
    end
    InstrValid = 1'b0;
    chk("add.accepts", accepts[7:0], 8'd3);
    chk("add.reads", reads[7:0], 8'd3);
    tick();
    chkIdle("add.end");

    // 6: STA R3 and opcode F
`ifdef REGCTRL_ILLEGAL_TRAP_EN
    issue(8'h2C);
    tick();
    chk("ill2C.IllegalOp", {7'd0, IllegalOp}, 8'd1);
    chk("ill2C.RegCE", {7'd0, RegCE}, 8'd0);
    chk("ill2C.AccCE", {7'd0, AccCE}, 8'd0);
    InstrValid = 1'b1;
    Instr = 8'h12;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("halt.k%0d.InstrReady", k), {7'd0, InstrReady}, 8'd0);
      chk($sformatf("halt.k%0d.Busy", k), {7'd0, Busy}, 8'd1);
      chk($sformatf("halt.k%0d.AccCE", k), {7'd0, AccCE}, 8'd0);
      chk($sformatf("halt.k%0d.IllegalOp", k), {7'd0, IllegalOp}, 8'd1);
    end
    InstrValid = 1'b0;
    doReset();
    chkIdle("halt.reset");
    issue(8'hF0);
    tick();
    chk("illF0.IllegalOp", {7'd0, IllegalOp}, 8'd1);
    tick();
    chk("illF0.InstrReady", {7'd0, InstrReady}, 8'd0);
    chk("illF0.RegCE", {7'd0, RegCE}, 8'd0);
    doReset();
    chkIdle("illF0.reset");
`else
    issue(8'h2C);
    tick();
    chk("ill2C.e1.RegCE", {7'd0, RegCE}, 8'd0);
    chk("ill2C.e1.AccCE", {7'd0, AccCE}, 8'd0);
    chk("ill2C.e1.IllegalOp", {7'd0, IllegalOp}, 8'd0);
    tick();
    chkIdle("ill2C.e2");
    issue(8'hF0);
    tick();
    chk("illF0.e1.RegCE", {7'd0, RegCE}, 8'd0);
    chk("illF0.e1.AccCE", {7'd0, AccCE}, 8'd0);
    tick();
    chkIdle("illF0.e2");
`endif

    // Legal instruction still works after the illegal-op checks
    issue(8'h57);
    tick();
    chk("and.AccCE", {7'd0, AccCE}, 8'd1);
    chk("and.AluOp", {5'd0, AluOp}, 8'd3);
    chk("and.RegNum", {4'd0, RegNum}, 8'h08);
    tick();
    chkIdle("and.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
